// File: rtl/pwm_ctrl_pkg.sv
// Shared types and level encodings for the PWM duty-cycle ramp sequencer.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        STOP = 2'd2
    } ramp_state_t;

    typedef logic [1:0] duty_level_t;

    // Duty-cycle level encodings understood by the PWM generator
    localparam duty_level_t LVL_OFF = 2'd0;
    localparam duty_level_t LVL_75  = 2'd1;
    localparam duty_level_t LVL_875 = 2'd2;
    localparam duty_level_t LVL_99  = 2'd3;

    // One level closer to tgt; callers guarantee cur != tgt
    function automatic duty_level_t step_toward(input duty_level_t cur, input duty_level_t tgt);
        if (tgt > cur) begin
            return cur + 2'd1;
        end
        return cur - 2'd1;
    endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running period counter kept phase-aligned with the PWM generator.
// boundary marks the last cycle of a period, period_start the first.
module pwm_period_timer #(
    parameter int unsigned PERIOD = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [$clog2(PERIOD)-1:0] count,
    output logic                      boundary,
    output logic                      period_start
);

    localparam int unsigned CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    assign boundary     = (count == LAST);
    assign period_start = (count == '0);

    // Count 0..PERIOD-1 and wrap; never stalled, so phase tracks the generator
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (boundary) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_ramp_controller.sv
// Duty-cycle ramp sequencer: accepts target levels over valid/ready and walks
// duty_cycle one level per step, steps only on period boundaries with a dwell
// of DWELL_PERIODS boundaries between them. estop forces the output off at once.
module pwm_ramp_controller
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned PERIOD        = 256,
    parameter int unsigned DWELL_PERIODS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_level,
    output logic        req_ready,
    input  logic        estop,
    output logic [1:0]  duty_cycle,
    output logic        busy,
    output logic        at_target,
    output logic        period_start
);

    localparam int unsigned CW  = $clog2(PERIOD);
    localparam int unsigned DWW = (DWELL_PERIODS > 1) ? $clog2(DWELL_PERIODS) : 1;
    localparam logic [DWW-1:0] DW_RELOAD = DWW'(DWELL_PERIODS - 1);

    logic [CW-1:0]  cnt;
    logic           boundary;
    logic           unused_cnt;

    ramp_state_t    state_q, state_d;
    duty_level_t    target_q, target_d;
    duty_level_t    duty_q, duty_d;
    logic [DWW-1:0] dw_q, dw_d;
    duty_level_t    next_level;

    pwm_period_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .count        (cnt),
        .boundary     (boundary),
        .period_start (period_start)
    );

    // Only the timer's decoded pulses are needed here
    assign unused_cnt = ^cnt;

    assign next_level = step_toward(duty_q, target_q);

    // Next-state logic: estop dominates, otherwise the IDLE/RAMP/STOP sequence
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        duty_d   = duty_q;
        dw_d     = dw_q;

        if (estop) begin
            state_d  = STOP;
            target_d = LVL_OFF;
            duty_d   = LVL_OFF;
            dw_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        target_d = req_level;
                        dw_d     = '0;
                        if (req_level != duty_q) begin
                            state_d = RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (boundary) begin
                        if (dw_q == '0) begin
                            duty_d = next_level;
                            dw_d   = DW_RELOAD;
                            // busy drops on the same edge the target is reached
                            if (next_level == target_q) begin
                                state_d = IDLE;
                            end
                        end else begin
                            dw_d = dw_q - 1'b1;
                        end
                    end
                end
                STOP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers; reset aborts any ramp immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            target_q <= LVL_OFF;
            duty_q   <= LVL_OFF;
            dw_q     <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            duty_q   <= duty_d;
            dw_q     <= dw_d;
        end
    end

    assign duty_cycle = duty_q;
    assign req_ready  = (state_q == IDLE) && !estop;
    assign busy       = (state_q == RAMP);
    assign at_target  = (duty_q == target_q);

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller with PERIOD=8, DWELL_PERIODS=2.
// Expected duty_cycle transitions are queued as requests are issued and
// consumed by a negedge monitor that also checks period_start phase.
module tb_pwm_ramp_controller;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_level;
    logic       req_ready;
    logic       estop;
    logic [1:0] duty_cycle;
    logic       busy;
    logic       at_target;
    logic       period_start;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt;

    typedef struct {
        logic [1:0] level;
        bit         aligned;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] prev_duty;

    pwm_ramp_controller #(
        .PERIOD        (8),
        .DWELL_PERIODS (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_level    (req_level),
        .req_ready    (req_ready),
        .estop        (estop),
        .duty_cycle   (duty_cycle),
        .busy         (busy),
        .at_target    (at_target),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference period counter, reset together with the DUT
    always @(posedge clk or negedge reset) begin
        if (!reset) model_cnt <= 0;
        else        model_cnt <= (model_cnt == 7) ? 0 : model_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] lvl, input bit al);
        exp_t e;
        e.level   = lvl;
        e.aligned = al;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (model_cnt != v && n < 16) begin
            tick(1);
            n++;
        end
        check("wait_cnt", model_cnt, v);
    endtask

    // Counts edges until duty_cycle reaches lvl and checks the latency
    task automatic wait_duty(input logic [1:0] lvl, input int exp_cycles, input string tag);
        int n = 0;
        while (duty_cycle !== lvl && n < 40) begin
            tick(1);
            n++;
        end
        check(tag, n, exp_cycles);
    endtask

    task automatic accept(input logic [1:0] lvl, input string tag);
        req_valid = 1'b1;
        req_level = lvl;
        check({tag, "_ready"}, req_ready, 1);
        tick(1);
        req_valid = 1'b0;
    endtask

    // Scoreboard consumer and period_start phase check
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            prev_duty <= 2'd0;
        end else begin
            check("period_start", period_start, model_cnt == 0);
            if (duty_cycle !== prev_duty) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", duty_cycle, prev_duty);
                end else begin
                    e = sb.pop_front();
                    check("sb_level", duty_cycle, e.level);
                    if (e.aligned) check("sb_align", model_cnt, 0);
                end
            end
            prev_duty <= duty_cycle;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        estop     = 1'b0;
        req_valid = 1'b0;
        req_level = 2'd0;

        #12;
        check("rst_duty", duty_cycle, 0);
        check("rst_busy", busy, 0);
        check("rst_at_target", at_target, 1);
        check("rst_ready", req_ready, 1);
        check("rst_pstart", period_start, 1);
        #15;
        reset = 1'b1;
        tick(1);

        // Up-ramp 0 -> 3 accepted at cnt 2
        wait_cnt(2);
        push(2'd1, 1'b1);
        push(2'd2, 1'b1);
        push(2'd3, 1'b1);
        accept(2'd3, "up");
        check("up_busy", busy, 1);
        check("up_ready_lo", req_ready, 0);
        wait_duty(2'd1, 5, "up_s1");
        check("up_ready_ramp", req_ready, 0);
        wait_duty(2'd2, 16, "up_s2");
        check("up_busy_mid", busy, 1);
        wait_duty(2'd3, 16, "up_s3");
        check("up_busy_end", busy, 0);
        check("up_at_target", at_target, 1);
        check("up_ready_end", req_ready, 1);

        // Down-ramp 3 -> 1
        push(2'd2, 1'b1);
        push(2'd1, 1'b1);
        accept(2'd1, "dn");
        wait_duty(2'd2, 7, "dn_s1");
        wait_duty(2'd1, 16, "dn_s2");
        check("dn_busy_end", busy, 0);
        check("dn_at_target", at_target, 1);

        // 1 -> 2, then a request equal to the current level
        push(2'd2, 1'b1);
        accept(2'd2, "up2");
        wait_duty(2'd2, 7, "up2_s1");
        check("up2_busy_end", busy, 0);
        accept(2'd2, "eq");
        check("eq_busy", busy, 0);
        check("eq_duty", duty_cycle, 2);
        check("eq_at_target", at_target, 1);
        tick(3);
        check("eq_busy_later", busy, 0);

        // Accept on a boundary: step waits for the following boundary
        wait_cnt(7);
        push(2'd3, 1'b1);
        accept(2'd3, "bnd");
        check("bnd_busy", busy, 1);
        wait_duty(2'd3, 8, "bnd_s1");

        // estop mid-ramp at level 2, cnt 4, with a competing request
        push(2'd2, 1'b1);
        accept(2'd0, "es");
        wait_duty(2'd2, 7, "es_s1");
        wait_cnt(4);
        estop     = 1'b1;
        req_valid = 1'b1;
        req_level = 2'd3;
        check("es_ready_comb", req_ready, 0);
        push(2'd0, 1'b0);
        tick(1);
        check("es_duty", duty_cycle, 0);
        check("es_busy", busy, 0);
        check("es_ready", req_ready, 0);
        check("es_at_target", at_target, 1);
        tick(1);
        check("es_duty_hold", duty_cycle, 0);
        estop = 1'b0;
        check("stop_ready", req_ready, 0);
        tick(1);
        req_valid = 1'b0;
        check("es_rel_ready", req_ready, 1);
        check("es_rel_busy", busy, 0);
        check("es_rel_duty", duty_cycle, 0);
        check("es_rel_at_target", at_target, 1);
        tick(1);
        check("es_no_accept", busy, 0);
        accept(2'd0, "es_zero");
        check("es_zero_busy", busy, 0);
        check("es_zero_at_target", at_target, 1);

        // Asynchronous reset mid-ramp
        wait_cnt(3);
        push(2'd1, 1'b1);
        push(2'd2, 1'b1);
        accept(2'd2, "rst");
        wait_duty(2'd1, 4, "rst_s1");
        tick(5);
        #2;
        reset = 1'b0;
        #1;
        check("arst_duty", duty_cycle, 0);
        check("arst_busy", busy, 0);
        check("arst_pstart", period_start, 1);
        check("arst_at_target", at_target, 1);
        sb.delete();
        #9;
        reset = 1'b1;
        tick(1);
        push(2'd1, 1'b1);
        accept(2'd1, "post_rst");
        wait_duty(2'd1, 6, "post_rst_s1");
        check("post_rst_busy", busy, 0);

        tick(2);
        check("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_controller.md
# pwm_ramp_controller

Sequencer that drives the 2-bit `duty_cycle` input of the PWM generator. It accepts target-level requests over a valid/ready handshake and ramps the output one level at a time. Level changes happen only on PWM period boundaries, with a programmable dwell between steps. An emergency-stop input forces the output off immediately. The block sits between the control logic (FSM or user I/O) and the PWM generator and is the only writer of `duty_cycle`.

## Interface
- `PERIOD`, default 256: PWM period in clock cycles; must equal the generator's period; ≥ 2.
- `DWELL_PERIODS`, default 4: boundaries between successive steps; ≥ 1.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-low reset; 0 = reset.
- `req_valid` in 1: target-level request valid.
- `req_level` in 2: requested level (0 = off, 1 = 75 %, 2 = 87.5 %, 3 = 99 %).
- `req_ready` out 1: request accepted this cycle when `req_valid && req_ready`.
- `estop` in 1: emergency stop, level-sensitive, synchronous sample.
- `duty_cycle` out 2: registered level to the PWM generator.
- `busy` out 1: ramp in progress.
- `at_target` out 1: `duty_cycle == target`.
- `period_start` out 1: one-cycle pulse while the internal period counter is 0.

## Operation
- Internal period counter `cnt` counts 0..PERIOD-1 and wraps. A boundary is a cycle with `cnt == PERIOD-1`. The counter leaves reset together with the generator, so the two stay phase-aligned.
- Registered state: `state` ∈ {IDLE, RAMP, STOP}, `target[1:0]`, `duty_cycle[1:0]`, dwell counter `dw`.
- `req_ready = (state == IDLE) && !estop`. This is combinational.
- IDLE, on accept:
  - `target <= req_level` and `dw <= 0`.
  - If `req_level == duty_cycle`, stay in IDLE.
  - Otherwise go to RAMP.
- RAMP, on each boundary:
  - If `dw == 0`: `duty_cycle` moves one step toward `target` (+1 or -1), and `dw <= DWELL_PERIODS-1`. If the new level equals `target`, go to IDLE on the same edge.
  - Else: `dw <= dw - 1`.
- RAMP applies to both up and down ramps. Requests are not accepted in RAMP; the requester holds `req_valid`.
- Any state, `estop == 1`:
  - Next edge: `duty_cycle <= 0`, `target <= 0`, `dw <= 0`, state STOP. This is not boundary-aligned.
  - `estop` overrides everything, including an accept in the same cycle (ready is 0).
- STOP:
  - `duty_cycle` held at 0 and `req_ready = 0`.
  - The first cycle with `estop == 0` moves to IDLE on the next edge.
- `busy = (state == RAMP)`.
- `at_target = (duty_cycle == target)`. It is 1 in IDLE and in STOP.

## Timing
- Reset values, async on `reset == 0`:
  - `cnt = 0`, `state = IDLE`, `target = 0`, `duty_cycle = 0`, `dw = 0`.
  - Outputs: `busy = 0`, `at_target = 1`, `period_start = 1`.
  - `req_ready = 1` when `estop == 0`.
- Accept at cycle t: `busy` rises at t+1.
- First step takes effect on the edge ending the first boundary after t, so the new level is valid when `cnt == 0`.
  - If the accept cycle is itself a boundary, `dw` is loaded with 0 at that edge and the step occurs at the *next* boundary.
- Subsequent steps come every `DWELL_PERIODS × PERIOD` cycles.
- A k-level ramp finishes (k-1)·DWELL_PERIODS·PERIOD cycles after the first step. `busy` falls on the same edge that `duty_cycle` reaches `target`.
- `duty_cycle` changes mid-period only on estop or reset.
- Reset asserted mid-ramp aborts the ramp immediately. No state survives reset.
- `cnt` is unaffected by estop; it runs continuously.

## Structure
- Package `pwm_ctrl_pkg`:
  - `typedef enum logic [1:0] {IDLE, RAMP, STOP} ramp_state_t`.
  - Level constants `LVL_OFF = 0`, `LVL_75 = 1`, `LVL_875 = 2`, `LVL_99 = 3`.
  - `typedef logic [1:0] duty_level_t`.
- One sub-module, `pwm_period_timer`:
  - Parameter `PERIOD`; output `$clog2(PERIOD)`-bit count, `boundary` and `period_start` pulses.
  - Async active-low reset.
- Top level holds the FSM, `target`, `dw` and `duty_cycle` registers.

## Test plan
All scenarios use `PERIOD = 8`, `DWELL_PERIODS = 2`.
- Reset release: outputs `duty_cycle = 0`, `busy = 0`, `at_target = 1`, `req_ready = 1`; `period_start` pulses every 8 cycles.
- Accept `req_level = 3` at `cnt = 2`:
  - `duty_cycle` goes 1 at the next `cnt = 0` (6 cycles later).
  - It goes 2 16 cycles later and 3 a further 16 cycles later.
  - `busy` falls with the step to 3, and `req_ready` stays 0 during the ramp.
- From level 3, request 1: two downward steps 16 cycles apart, 3→2→1, then IDLE.
- Request equal to the current level (2 → 2): accepted in one cycle, `busy` never asserts, `duty_cycle` unchanged.
- `estop` pulsed mid-ramp at level 2 with `cnt = 4`:
  - `duty_cycle = 0` on the next edge, state STOP, `req_ready = 0`, and `req_valid` is ignored.
  - After release: IDLE, `target = 0`, `at_target = 1`.
- `reset` asserted asynchronously mid-ramp (between edges): `duty_cycle` and `cnt` go to 0 immediately. A new request after release ramps from 0.
